// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard controller slice.
package hazard_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_t;

   localparam int unsigned REG_ZERO       = 0;
   localparam int unsigned MD_LAT_DEFAULT = 4;

endpackage

// File: rtl/hazard_scoreboard_md.sv
// md_scoreboard: tracks the single in-flight multiply/divide op and its
// destination register with a countdown from issue to completion.
module md_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned MD_LAT = MD_LAT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue,
   input  logic [REG_AW-1:0] issue_rd,
   output logic              md_busy,
   output logic              md_done,
   output logic              pend_v,
   output logic [REG_AW-1:0] pend_rd
);

   localparam int unsigned CW = $clog2(MD_LAT);

   md_state_t         state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              pend_v_q, pend_v_d;
   logic [REG_AW-1:0] pend_rd_q, pend_rd_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_v_d  = pend_v_q;
      pend_rd_d = pend_rd_q;
      case (state_q)
         IDLE: begin
            if (issue) begin
               state_d   = BUSY;
               cnt_d     = CW'(MD_LAT - 1);
               pend_v_d  = (issue_rd != REG_AW'(REG_ZERO));
               pend_rd_d = issue_rd;
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               state_d  = IDLE;
               pend_v_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pend_v_q  <= 1'b0;
         pend_rd_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_v_q  <= pend_v_d;
         pend_rd_q <= pend_rd_d;
      end
   end

   assign md_busy = (state_q == BUSY);
   assign md_done = (state_q == BUSY) && (cnt_q == '0);
   assign pend_v  = pend_v_q;
   assign pend_rd = pend_rd_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW/WAW/structural stall control beside ID.
// Define HAZARD_PERF_EN to add the saturating stall_count output.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned MD_LAT = MD_LAT_DEFAULT,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              id_is_branch,
   input  logic              id_reg_write,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_is_md,
   input  logic              idex_mem_read,
   input  logic              idex_reg_write,
   input  logic [REG_AW-1:0] idex_rd,
   input  logic              exmem_mem_read,
   input  logic [REG_AW-1:0] exmem_rd,
   output logic              stall,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              idex_bubble,
   output logic              md_busy,
`ifdef HAZARD_PERF_EN
   output logic [CNT_W-1:0]  stall_count,
`endif
   output logic              md_done
);

   if (MD_LAT < 2 || MD_LAT > 255) begin : g_bad_lat
      $error("hazard_scoreboard: MD_LAT out of range 2..255");
   end
   if (CNT_W < 1) begin : g_bad_cnt
      $error("hazard_scoreboard: CNT_W must be at least 1");
   end

   logic              pend_v;
   logic [REG_AW-1:0] pend_rd;
   logic              pipe_stall;
   logic              sb_stall;
   logic              issue;

   function automatic logic src_hit(input logic [REG_AW-1:0] r);
      return id_valid && r != REG_AW'(REG_ZERO) &&
             ((id_uses_rs && id_rs == r) || (id_uses_rt && id_rt == r));
   endfunction

   // Scoreboard terms are masked during reset so only pipeline-register hazards remain.
   always_comb begin
      pipe_stall = (idex_mem_read && src_hit(idex_rd)) ||
                   (id_is_branch && idex_reg_write && src_hit(idex_rd)) ||
                   (id_is_branch && exmem_mem_read && src_hit(exmem_rd));
      sb_stall   = (pend_v && src_hit(pend_rd)) ||
                   (pend_v && id_valid && id_reg_write && id_rd == pend_rd &&
                    id_rd != REG_AW'(REG_ZERO)) ||
                   (id_valid && id_is_md && md_busy);
      stall      = pipe_stall || (sb_stall && !rst);
   end

   assign pc_write    = !stall;
   assign ifid_write  = !stall;
   assign idex_bubble = stall;
   assign issue       = id_valid && id_is_md && !stall;

   md_scoreboard #(
      .REG_AW (REG_AW),
      .MD_LAT (MD_LAT)
   ) u_md (
      .clk      (clk),
      .rst      (rst),
      .issue    (issue),
      .issue_rd (id_rd),
      .md_busy  (md_busy),
      .md_done  (md_done),
      .pend_v   (pend_v),
      .pend_rd  (pend_rd)
   );

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && stall_count_q != '1) begin
         stall_count_d = stall_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard (MD_LAT=4, CNT_W=4).
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_uses_rs, id_uses_rt, id_is_branch, id_reg_write, id_is_md;
   logic [4:0] id_rs, id_rt, id_rd, idex_rd, exmem_rd;
   logic       idex_mem_read, idex_reg_write, exmem_mem_read;
   logic       stall, pc_write, ifid_write, idex_bubble, md_busy, md_done;
`ifdef HAZARD_PERF_EN
   logic [3:0] stall_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_scoreboard #(
      .REG_AW (5),
      .MD_LAT (4),
      .CNT_W  (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .id_valid       (id_valid),
      .id_rs          (id_rs),
      .id_rt          (id_rt),
      .id_uses_rs     (id_uses_rs),
      .id_uses_rt     (id_uses_rt),
      .id_is_branch   (id_is_branch),
      .id_reg_write   (id_reg_write),
      .id_rd          (id_rd),
      .id_is_md       (id_is_md),
      .idex_mem_read  (idex_mem_read),
      .idex_reg_write (idex_reg_write),
      .idex_rd        (idex_rd),
      .exmem_mem_read (exmem_mem_read),
      .exmem_rd       (exmem_rd),
      .stall          (stall),
      .pc_write       (pc_write),
      .ifid_write     (ifid_write),
      .idex_bubble    (idex_bubble),
      .md_busy        (md_busy),
`ifdef HAZARD_PERF_EN
      .stall_count    (stall_count),
`endif
      .md_done        (md_done)
   );

   typedef struct {
      logic       valid, uses_rs, uses_rt, is_branch;
      logic [4:0] rs, rt;
      logic       idex_mr, idex_rw;
      logic [4:0] idex_rd;
      logic       exmem_mr;
      logic [4:0] exmem_rd;
      logic       exp_stall;
      string      name;
   } vec_t;

   typedef struct {
      logic  stall, busy, done;
      string name;
   } exp_t;

   exp_t exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic clr();
      rst = 1'b0; id_valid = 1'b0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
      id_is_branch = 1'b0; id_reg_write = 1'b0; id_is_md = 1'b0;
      id_rs = '0; id_rt = '0; id_rd = '0; idex_rd = '0; exmem_rd = '0;
      idex_mem_read = 1'b0; idex_reg_write = 1'b0; exmem_mem_read = 1'b0;
   endtask

   // Push the expectation for the current cycle, compare at negedge, advance.
   task automatic step(input logic s, input logic b, input logic d, input string nm);
      exp_t e;
      exp_q.push_back('{stall: s, busy: b, done: d, name: nm});
      @(negedge clk);
      e = exp_q.pop_front();
      chk({e.name, ".stall"}, 32'(stall), 32'(e.stall));
      chk({e.name, ".pc_write"}, 32'(pc_write), 32'(!e.stall));
      chk({e.name, ".ifid_write"}, 32'(ifid_write), 32'(!e.stall));
      chk({e.name, ".idex_bubble"}, 32'(idex_bubble), 32'(e.stall));
      chk({e.name, ".md_busy"}, 32'(md_busy), 32'(e.busy));
      chk({e.name, ".md_done"}, 32'(md_done), 32'(e.done));
      @(posedge clk);
      #1;
   endtask

   task automatic issue_md(input logic [4:0] rd, input string nm);
      clr();
      id_valid = 1'b1; id_is_md = 1'b1; id_reg_write = 1'b1; id_rd = rd;
      step(1'b0, 1'b0, 1'b0, nm);
   endtask

   task automatic drain();
      clr();
      for (int i = 0; i < 6; i++) @(posedge clk);
      #1;
   endtask

   vec_t vecs[10];

   initial begin
      //          v  urs urt br  rs  rt  imr irw ird emr erd  exp
      vecs[0] = '{1, 1,  0,  0,  8,  0,  1,  1,  8,  0,  0,  1, "lu_rs"};
      vecs[1] = '{1, 1,  0,  0,  8,  0,  1,  1,  0,  0,  0,  0, "lu_rd0"};
      vecs[2] = '{1, 1,  0,  0,  0,  0,  1,  1,  0,  0,  0,  0, "lu_r0_r0"};
      vecs[3] = '{1, 0,  0,  0,  8,  0,  1,  1,  8,  0,  0,  0, "lu_unused"};
      vecs[4] = '{1, 0,  1,  0,  0,  8,  1,  1,  8,  0,  0,  1, "lu_rt"};
      vecs[5] = '{0, 1,  0,  0,  8,  0,  1,  1,  8,  0,  0,  0, "lu_invalid"};
      vecs[6] = '{1, 0,  1,  1,  0,  9,  0,  0,  0,  1,  9,  1, "br_mem_ld"};
      vecs[7] = '{1, 0,  1,  1,  0,  9,  0,  0,  0,  0,  9,  0, "br_mem_noload"};
      vecs[8] = '{1, 0,  1,  1,  0,  9,  0,  1,  9,  0,  0,  1, "br_alu"};
      vecs[9] = '{1, 0,  1,  0,  0,  9,  0,  1,  9,  0,  0,  0, "alu_nobranch"};

      clr();
      rst = 1'b1;
      @(posedge clk); #1;
      step(1'b0, 1'b0, 1'b0, "reset");
`ifdef HAZARD_PERF_EN
      chk("reset.stall_count", 32'(stall_count), 32'd0);
`endif
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         clr();
         id_valid = vecs[i].valid; id_uses_rs = vecs[i].uses_rs; id_uses_rt = vecs[i].uses_rt;
         id_is_branch = vecs[i].is_branch; id_rs = vecs[i].rs; id_rt = vecs[i].rt;
         idex_mem_read = vecs[i].idex_mr; idex_reg_write = vecs[i].idex_rw;
         idex_rd = vecs[i].idex_rd; exmem_mem_read = vecs[i].exmem_mr; exmem_rd = vecs[i].exmem_rd;
         step(vecs[i].exp_stall, 1'b0, 1'b0, vecs[i].name);
      end

      // RAW: reader of r10 stalls cycles 1-4, done at 4, released at 5.
      issue_md(5'd10, "raw.c0");
      clr();
      id_valid = 1'b1; id_uses_rs = 1'b1; id_rs = 5'd10;
      for (int c = 1; c <= 4; c++) step(1'b1, 1'b1, c == 4, $sformatf("raw.c%0d", c));
      step(1'b0, 1'b0, 1'b0, "raw.c5");
      drain();

      // Structural: second md presented from cycle 2 issues at cycle 5.
      issue_md(5'd10, "str.c0");
      clr();
      step(1'b0, 1'b1, 1'b0, "str.c1");
      id_valid = 1'b1; id_is_md = 1'b1; id_reg_write = 1'b1; id_rd = 5'd11;
      for (int c = 2; c <= 4; c++) step(1'b1, 1'b1, c == 4, $sformatf("str.c%0d", c));
      step(1'b0, 1'b0, 1'b0, "str.c5");
      clr();
      for (int c = 6; c <= 9; c++) step(1'b0, 1'b1, c == 9, $sformatf("str.c%0d", c));
      step(1'b0, 1'b0, 1'b0, "str.c10");

      // WAW: non-md write to r10 stalls while pending.
      issue_md(5'd10, "waw.c0");
      clr();
      id_valid = 1'b1; id_reg_write = 1'b1; id_rd = 5'd10;
      for (int c = 1; c <= 4; c++) step(1'b1, 1'b1, c == 4, $sformatf("waw.c%0d", c));
      step(1'b0, 1'b0, 1'b0, "waw.c5");
      drain();

      // md to r0 occupies the unit but raises no RAW/WAW.
      issue_md(5'd0, "r0.c0");
      clr();
      id_valid = 1'b1; id_reg_write = 1'b1; id_rd = 5'd0; id_uses_rs = 1'b1; id_rs = 5'd0;
      step(1'b0, 1'b1, 1'b0, "r0.c1");
      clr();
      id_valid = 1'b1; id_is_md = 1'b1; id_rd = 5'd12;
      step(1'b1, 1'b1, 1'b0, "r0.struct");
      drain();

      // Reset mid-op: pipeline terms still act during rst, op is abandoned.
      issue_md(5'd10, "rst.c0");
      clr();
      id_valid = 1'b1; id_uses_rs = 1'b1; id_rs = 5'd10;
      step(1'b1, 1'b1, 1'b0, "rst.c1");
      rst = 1'b1;
      step(1'b0, 1'b1, 1'b0, "rst.c2_sbmask");
      rst = 1'b0;
      step(1'b0, 1'b0, 1'b0, "rst.c3");
      rst = 1'b1; idex_mem_read = 1'b1; idex_rd = 5'd10;
      step(1'b1, 1'b0, 1'b0, "rst.pipe_term");
      rst = 1'b0; idex_mem_read = 1'b0;

`ifdef HAZARD_PERF_EN
      clr();
      rst = 1'b1; idex_mem_read = 1'b1; idex_rd = 5'd8; id_valid = 1'b1; id_uses_rs = 1'b1; id_rs = 5'd8;
      @(posedge clk); #1;
      chk("perf.reset", 32'(stall_count), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) @(posedge clk);
      #1;
      chk("perf.count10", 32'(stall_count), 32'd10);
      for (int i = 0; i < 10; i++) @(posedge clk);
      #1;
      chk("perf.saturate", 32'(stall_count), 32'd15);
      clr();
      @(posedge clk); #1;
      chk("perf.hold", 32'(stall_count), 32'd15);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Pipeline hazard controller for the 5-stage core, sitting beside the ID stage.
- Detects load-use and branch-in-ID RAW hazards against ID/EX and EX/MEM.
- Tracks one in-flight multi-cycle multiply/divide op with a countdown scoreboard.
- Produces the stall and bubble controls for PC, IF/ID and ID/EX.
- Optionally counts stall cycles for performance analysis.

## Interface
Parameters:
- REG_AW, 5, register address width; register 0 is hard-wired zero.
- MD_LAT, 4, multiply/divide latency in cycles, counted from issue; legal range 2..255.
- CNT_W, 16, stall counter width; used only with HAZARD_PERF_EN.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_AW  ID source registers.
- id_uses_rs, id_uses_rt  in  1  source is actually read.
- id_is_branch  in  1  branch resolved in ID; needs operands in ID.
- id_reg_write, id_rd  in  1, REG_AW  ID instruction writes id_rd.
- id_is_md  in  1  ID instruction is a multiply/divide issue; its destination is id_rd.
- idex_mem_read, idex_reg_write  in  1  ID/EX control bits.
- idex_rd  in  REG_AW  ID/EX destination.
- exmem_mem_read  in  1  EX/MEM is a load.
- exmem_rd  in  REG_AW  EX/MEM destination.
- stall  out  1  hold the ID instruction this cycle.
- pc_write, ifid_write  out  1  equal to !stall.
- idex_bubble  out  1  equal to stall; zeroes the ID/EX control bits.
- md_busy  out  1  multiply/divide op in flight.
- md_done  out  1  one-cycle pulse in the final busy cycle.
- stall_count  out  CNT_W  present only with HAZARD_PERF_EN.

## Operation
Source matching:
- src_hit(r) = id_valid && ((id_uses_rs && id_rs==r) || (id_uses_rt && id_rt==r)) && r!=0.

Hazard terms (OR together to form stall):
- Load-use: idex_mem_read && src_hit(idex_rd).
- Branch vs. ALU result: id_is_branch && idex_reg_write && src_hit(idex_rd).
- Branch vs. load in MEM: id_is_branch && exmem_mem_read && src_hit(exmem_rd).
- Scoreboard RAW: pend_v && src_hit(pend_rd).
- Scoreboard WAW: pend_v && id_valid && id_reg_write && id_rd==pend_rd && id_rd!=0.
- Structural: id_valid && id_is_md && state==BUSY.

Multiply/divide state machine:
- States are IDLE and BUSY; cnt has width $clog2(MD_LAT).
- Issue = id_valid && id_is_md && !stall.
- IDLE, on issue: go to BUSY, cnt<=MD_LAT-1, pend_v<=(id_rd!=0), pend_rd<=id_rd.
- BUSY, cnt!=0: cnt<=cnt-1.
- BUSY, cnt==0: md_done=1; next cycle goes to IDLE with pend_v<=0.
- md_busy = (state==BUSY).
- An issue to rd 0 occupies the unit but never causes RAW or WAW stalls.

## Timing
- Stall terms and pc_write/ifid_write/idex_bubble are combinational from the inputs and registered state; no added latency.
- md_done asserts exactly MD_LAT cycles after the issue edge.
- A dependent instruction stalls through the md_done cycle. It is released the following cycle, once the result has been written to the register file.
- A new md op may issue in the cycle after md_done, but not in the md_done cycle itself (structural term is still true).
- Reset values: state=IDLE, cnt=0, pend_v=0, pend_rd=0, md_busy=0, md_done=0, stall_count=0.
- While rst is high, stall follows only the pipeline-register terms.
- Reset during BUSY abandons the op; the next cycle is IDLE with no pending register.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_count exists.
  - Increments on every non-reset cycle with stall=1.
  - Saturates at all-ones and never wraps.
- HAZARD_PERF_EN undefined: no counter and no stall_count port.
- Hazard behaviour is identical in both builds.

## Structure
- Shared package hazard_pkg holds:
  - the md_state_t enum {IDLE, BUSY};
  - the REG_ZERO constant;
  - the MD_LAT default.
- One sub-module, md_scoreboard, owns the state machine, cnt, pend_v and pend_rd. It outputs md_busy, md_done, pend_v and pend_rd.
- The top level holds the comparators and the optional counter.

## Test plan
- Load-use: idex_mem_read=1, idex_rd=8, id_rs=8, id_uses_rs=1 -> stall=1, pc_write=0, idex_bubble=1. Same stimulus with idex_rd=0 -> stall=0.
- Branch: id_is_branch=1, exmem_mem_read=1, exmem_rd=9, id_rt=9, id_uses_rt=1 -> stall=1. With exmem_mem_read=0 -> stall=0.
- Scoreboard RAW, MD_LAT=4:
  - Issue md to rd 10 at cycle 0.
  - md_done pulses at cycle 4.
  - A reader of r10 held in ID stalls in cycles 1-4 and is released in cycle 5.
- Structural and WAW:
  - A second md issued at cycle 2 stalls until cycle 5.
  - A non-md write to r10 during cycles 1-4 stalls.
- Reset mid-op: rst high at cycle 2 after issue -> md_busy=0 at cycle 3, and the r10 reader is not stalled.
- HAZARD_PERF_EN with CNT_W=4: 20 consecutive stall cycles -> stall_count=15 (saturated).
